// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/writeback over one shared
// memory port and one ALU. Supports lw, sw, R-type, addi, beq and j.
// Optional feature: define MC_INSTR_CNT_EN to add the retired-instruction counter instr_cnt.
module multicycle_control #(
  parameter int unsigned MAX_WAIT = 15
`ifdef MC_INSTR_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDest,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSrc,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic                 mem_err,
`ifdef MC_INSTR_CNT_EN
  output logic [CNT_WIDTH-1:0] instr_cnt,
`endif
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e     state_q;
  logic [5:0] op_q;
  logic [7:0] wait_q;
  logic       err_q;

  logic mem_state;
  logic timeout;
  logic wait_inc;
  logic op_legal;

  // Memory-wait bookkeeping: only the three states that touch the memory port can stall.
  always_comb begin
    mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    timeout   = mem_state && !mem_ready && (wait_q == WaitLast);
    wait_inc  = mem_state && !mem_ready && !timeout;
    op_legal  = (Opcode == OpRtype) || (Opcode == OpLw) || (Opcode == OpSw) ||
                (Opcode == OpAddi) || (Opcode == OpBeq) || (Opcode == OpJ);
  end

  // Sequencer state, captured opcode, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // Counter clears whenever the stall ends, the state is left, or a timeout fires.
      wait_q <= wait_inc ? (wait_q + 8'd1) : '0;
      case (state_q)
        StIdle: if (!err_q) state_q <= StFetch;
        StFetch: begin
          if (mem_ready) begin
            state_q <= StDecode;
          end else if (timeout) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end
        end
        StDecode: begin
          op_q <= Opcode;
          case (Opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StExec;
            OpAddi:     state_q <= StAddiEx;
            OpBeq:      state_q <= StBranch;
            OpJ:        state_q <= StJump;
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= (op_q == OpLw) ? StMemRd : StMemWr;
        StMemRd: begin
          if (mem_ready) begin
            state_q <= StMemWb;
          end else if (timeout) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end
        end
        StMemWb: state_q <= StFetch;
        StMemWr: begin
          if (mem_ready) begin
            state_q <= StFetch;
          end else if (timeout) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end
        end
        StExec:   state_q <= StAluWb;
        StAluWb:  state_q <= StFetch;
        StAddiEx: state_q <= StAddiWb;
        StAddiWb: state_q <= StFetch;
        StBranch: state_q <= StFetch;
        StJump:   state_q <= StFetch;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Moore control decode; only the memory strobes and illegal_op look at inputs.
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDest    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        illegal_op = !op_legal;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegWrite   = 1'b1;
        RegDest    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_err = err_q;
  assign state   = state_q;

`ifdef MC_INSTR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Retired-instruction counter; wraps naturally at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (instr_done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: route-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multicycle_control;

  localparam int MAXW = 15;
  localparam int CW   = 4;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDest, RegWrite;
  logic       ALUSrcA, instr_done, illegal_op, mem_err;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
`ifdef MC_INSTR_CNT_EN
  logic [CW-1:0] instr_cnt;
`endif

  always #5 clk = ~clk;

`ifdef MC_INSTR_CNT_EN
  multicycle_control #(.MAX_WAIT(MAXW), .CNT_WIDTH(CW)) dut (
`else
  multicycle_control #(.MAX_WAIT(MAXW)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .Opcode    (Opcode),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .Branch    (Branch),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .MemtoReg  (MemtoReg),
    .RegDest   (RegDest),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .instr_done(instr_done),
    .illegal_op(illegal_op),
    .mem_err   (mem_err),
`ifdef MC_INSTR_CNT_EN
    .instr_cnt (instr_cnt),
`endif
    .state     (state)
  );

  typedef struct packed {
    logic       pcw, br, iord, mrd, mwr, irw, m2r, rd, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       done, ill, err;
    logic [3:0] st;
  } ctl_t;

  ctl_t obs;
  assign obs = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDest, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op, mem_err, state};

  int   total = 0;
  int   bad = 0;
  ctl_t log_q[$];

  // Reference model: a step list per instruction instead of a transition table.
  int m_state = 0;
  int route[$];
  int m_wait = 0;
  bit m_err = 1'b0;
  int m_cnt = 0;
  bit started = 1'b0;

  function automatic ctl_t expect_out(int st, logic rdy, logic [5:0] op, bit err);
    ctl_t e;
    bit   legal;
    e     = '0;
    e.err = err;
    e.st  = 4'(st);
    legal = (op == LW) || (op == SW) || (op == RT) || (op == ADDI) || (op == BEQ) || (op == JMP);
    case (st)
      1:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      2:  begin e.srcb = 2'b11; e.ill = !legal; end
      3:  begin e.srca = 1; e.srcb = 2'b10; end
      4:  begin e.mrd = 1; e.iord = 1; end
      5:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
      6:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
      7:  begin e.srca = 1; e.aluop = 2'b10; end
      8:  begin e.rw = 1; e.rd = 1; e.done = 1; end
      9:  begin e.srca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.br = 1; e.done = 1; end
      10: begin e.srca = 1; e.srcb = 2'b10; end
      11: begin e.rw = 1; e.done = 1; end
      12: begin e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic plan_route(input logic [5:0] op);
    route.delete();
    case (op)
      LW:   begin route.push_back(3); route.push_back(4); route.push_back(5); end
      SW:   begin route.push_back(3); route.push_back(6); end
      RT:   begin route.push_back(7); route.push_back(8); end
      ADDI: begin route.push_back(10); route.push_back(11); end
      BEQ:  route.push_back(9);
      JMP:  route.push_back(12);
      default: ;
    endcase
  endtask

  task automatic advance();
    if (m_state == 1) m_state = 2;
    else if (route.size() > 0) m_state = route.pop_front();
    else m_state = 1;
  endtask

  task automatic model_step();
    ctl_t e;
    if (!rst_n) begin
      m_state = 0; m_wait = 0; m_err = 1'b0; m_cnt = 0;
      route.delete();
    end else begin
      e = expect_out(m_state, mem_ready, Opcode, m_err);
      if (e.done) m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_state == 0) begin
        if (!m_err) m_state = 1;
      end else if (m_state == 1 || m_state == 4 || m_state == 6) begin
        if (mem_ready) begin
          m_wait = 0;
          advance();
        end else if (m_wait == MAXW - 1) begin
          m_wait = 0; m_err = 1'b1; m_state = 0;
          route.delete();
        end else begin
          m_wait++;
        end
      end else begin
        if (m_state == 2) plan_route(Opcode);
        advance();
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      started = 1'b1;
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  initial begin
    ctl_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        e = expect_out(m_state, mem_ready, Opcode, m_err);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, obs, e);
        end
`ifdef MC_INSTR_CNT_EN
        total++;
        if (instr_cnt !== CW'(m_cnt)) begin
          bad++;
          $display("FAIL cycle_instr_cnt t=%0t got=%0d want=%0d", $time, instr_cnt, m_cnt);
        end
`endif
        log_q.push_back(obs);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // sel: 0 instr_done, 1 illegal_op, 2 RegWrite, 3 MemWrite
  function automatic int count_of(input int sel);
    int n = 0;
    foreach (log_q[i]) begin
      case (sel)
        0: n += int'(log_q[i].done);
        1: n += int'(log_q[i].ill);
        2: n += int'(log_q[i].rw);
        default: n += int'(log_q[i].mwr);
      endcase
    end
    return n;
  endfunction

  task automatic step(input logic [5:0] op, input logic rdy, input logic rst);
    Opcode    = op;
    mem_ready = rdy;
    rst_n     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lw_seq[7];
    lw_seq = '{0, 1, 2, 3, 4, 5, 1};

    // lw with zero-wait memory
    do_reset();
    repeat (7) step(LW, 1'b1, 1'b1);
    chk("reset_idle_outputs", int'(log_q[0]), 0);
    for (int k = 0; k < 7; k++) chk($sformatf("lw_state%0d", k), int'(log_q[k].st), lw_seq[k]);
    chk("lw_memwb_regwrite", int'(log_q[5].rw), 1);
    chk("lw_memwb_memtoreg", int'(log_q[5].m2r), 1);
    chk("lw_done_count", count_of(0), 1);

    // sw with three wait cycles in MEMWR
    do_reset();
    for (int k = 0; k < 9; k++) step(SW, (k < 4 || k > 6), 1'b1);
    chk("sw_memwrite_cycles", count_of(3), 4);
    chk("sw_done_count", count_of(0), 1);
    chk("sw_done_on_ready", int'(log_q[7].done), 1);
    chk("sw_no_regwrite", count_of(2), 0);

    // R-type, beq, j back to back
    do_reset();
    for (int k = 0; k < 12; k++) step((k <= 4) ? RT : ((k <= 7) ? BEQ : JMP), 1'b1, 1'b1);
    chk("rtype_exec_aluop", int'(log_q[3].aluop), 2);
    chk("beq_aluop", int'(log_q[7].aluop), 1);
    chk("j_pcsrc", int'(log_q[10].pcsrc), 2);
    chk("j_pcwrite", int'(log_q[10].pcw), 1);
    chk("rtype_done_c4", int'(log_q[4].done), 1);
    chk("beq_done_c7", int'(log_q[7].done), 1);
    chk("j_done_c10", int'(log_q[10].done), 1);
    chk("rbj_done_count", count_of(0), 3);

    // illegal opcode
    do_reset();
    repeat (4) step(BAD, 1'b1, 1'b1);
    chk("ill_pulse_decode", int'(log_q[2].ill), 1);
    chk("ill_back_to_fetch", int'(log_q[3].st), 1);
    chk("ill_count", count_of(1), 1);
    chk("ill_no_done", count_of(0), 0);
    chk("ill_no_regwrite", count_of(2), 0);
    chk("ill_no_memwrite", count_of(3), 0);

    // fetch timeout
    do_reset();
    step(LW, 1'b1, 1'b1);
    repeat (15) step(LW, 1'b0, 1'b1);
    repeat (5) step(LW, 1'b1, 1'b1);
    chk("to_last_fetch", int'(log_q[15].st), 1);
    chk("to_idle", int'(log_q[16].st), 0);
    chk("to_err_set", int'(log_q[16].err), 1);
    chk("to_idle_held", int'(log_q[20].st), 0);
    chk("to_err_held", int'(log_q[20].err), 1);
    do_reset();
    step(LW, 1'b1, 1'b1);
    chk("to_err_cleared", int'(log_q[0].err), 0);

    // ready on the last allowed wait cycle wins
    do_reset();
    step(LW, 1'b1, 1'b1);
    repeat (14) step(LW, 1'b0, 1'b1);
    step(LW, 1'b1, 1'b1);
    step(LW, 1'b1, 1'b1);
    chk("edge_ready_decode", int'(log_q[16].st), 2);
    chk("edge_ready_no_err", int'(log_q[16].err), 0);

    // reset during MEMRD
    do_reset();
    repeat (4) step(LW, 1'b1, 1'b1);
    step(LW, 1'b0, 1'b0);
    step(LW, 1'b1, 1'b0);
    step(LW, 1'b1, 1'b1);
    step(LW, 1'b1, 1'b1);
    chk("rst_in_memrd", int'(log_q[4].st), 4);
    chk("rst_idle_all_zero", int'(log_q[5]), 0);
    chk("rst_restart_fetch", int'(log_q[7].st), 1);

`ifdef MC_INSTR_CNT_EN
    // 16 retirements on a 4-bit counter wrap it to zero
    do_reset();
    step(RT, 1'b1, 1'b1);
    repeat (32) step(RT, 1'b1, 1'b1);
    chk("cnt_after_8", int'(instr_cnt), 8);
    repeat (32) step(RT, 1'b1, 1'b1);
    chk("cnt_wrap", int'(instr_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
